// File: rtl/regfile_sb_pkg.sv
// Shared widths and types for the register file with its reservation scoreboard.
package regfile_sb_pkg;
  localparam int WORD_W = 32;
  localparam int W_RD   = 5;
  localparam int NREG   = 2 ** W_RD;
  localparam int W_PEND = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [W_RD-1:0]   name_t;

  function automatic logic name_hit(input logic valid, input name_t a, input name_t b);
    return valid && (a == b);
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback port bundle: decode (master) drives names, reserve and wb; the file responds.
import regfile_sb_pkg::*;

interface regfile_sb_if;
  name_t rd_name;
  name_t rs_name;
  word_t rd_data;
  word_t rs_data;
  logic  rd_reserved;
  logic  rs_reserved;
  logic  rd_reserve;
  logic  wb;
  name_t wb_name;
  word_t wb_data;
  logic  err;

  modport master (
    output rd_name, rs_name, rd_reserve, wb, wb_name, wb_data,
    input  rd_data, rs_data, rd_reserved, rs_reserved, err
  );

  modport slave (
    input  rd_name, rs_name, rd_reserve, wb, wb_name, wb_data,
    output rd_data, rs_data, rd_reserved, rs_reserved, err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register saturating pending-write counters with retire bypass on the reserved flags.
import regfile_sb_pkg::*;

module rf_scoreboard #(
  parameter int NAME_W = W_RD,
  parameter int PEND_W = W_PEND
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reserve,
  input  logic [NAME_W-1:0] reserve_name,
  input  logic              wb,
  input  logic [NAME_W-1:0] wb_name,
  input  logic [NAME_W-1:0] rd_name,
  input  logic [NAME_W-1:0] rs_name,
  output logic              rd_reserved,
  output logic              rs_reserved,
  output logic              err
);
  localparam int N = 2 ** NAME_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_all [N];
  logic [N-1:0]      ovf;
  logic [N-1:0]      unf;
  logic              err_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      logic              inc;
      logic              dec;
      logic [PEND_W-1:0] cnt_reg;

      assign inc = reserve && (reserve_name == NAME_W'(gi));
      assign dec = wb && (wb_name == NAME_W'(gi));
      // A same-cycle reserve and retire cancel out, so neither can over/underflow.
      assign ovf[gi] = inc && !dec && (cnt_reg == CNT_MAX);
      assign unf[gi] = dec && !inc && (cnt_reg == '0);
      assign cnt_all[gi] = cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (inc && !dec && !ovf[gi]) begin
          cnt_reg <= cnt_reg + PEND_W'(1);
        end else if (dec && !inc && !unf[gi]) begin
          cnt_reg <= cnt_reg - PEND_W'(1);
        end
      end
    end
  endgenerate

  logic [PEND_W-1:0] rd_cnt;
  logic [PEND_W-1:0] rs_cnt;
  logic              rd_retire;
  logic              rs_retire;

  assign rd_cnt    = cnt_all[rd_name];
  assign rs_cnt    = cnt_all[rs_name];
  assign rd_retire = wb && (wb_name == rd_name);
  assign rs_retire = wb && (wb_name == rs_name);
  // The last pending write retiring this cycle reads as free; its data is bypassed.
  assign rd_reserved = rd_retire ? (rd_cnt > PEND_W'(1)) : (rd_cnt != '0);
  assign rs_reserved = rs_retire ? (rs_cnt > PEND_W'(1)) : (rs_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((|ovf) || (|unf)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
endmodule

// File: rtl/regfile_sb.sv
// Register file beside decode: zero-latency reads with writeback bypass, plus reservation scoreboard.
import regfile_sb_pkg::*;

module regfile_sb (
  input logic          clk,
  input logic          rst_n,
  regfile_sb_if.slave  rf
);
  word_t data_all [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      word_t data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (name_hit(rf.wb, rf.wb_name, name_t'(gi))) begin
          data_reg <= rf.wb_data;
        end
      end

      assign data_all[gi] = data_reg;
    end
  endgenerate

  assign rf.rd_data = name_hit(rf.wb, rf.wb_name, rf.rd_name) ? rf.wb_data : data_all[rf.rd_name];
  assign rf.rs_data = name_hit(rf.wb, rf.wb_name, rf.rs_name) ? rf.wb_data : data_all[rf.rs_name];

  rf_scoreboard #(
    .NAME_W (W_RD),
    .PEND_W (W_PEND)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .reserve      (rf.rd_reserve),
    .reserve_name (rf.rd_name),
    .wb           (rf.wb),
    .wb_name      (rf.wb_name),
    .rd_name      (rf.rd_name),
    .rs_name      (rf.rs_name),
    .rd_reserved  (rf.rd_reserved),
    .rs_reserved  (rf.rs_reserved),
    .err          (rf.err)
  );
endmodule
